bitty_fetch_unit: RTL

BITTY_FETCH_UNIT -- requirements
Module: bitty_fetch_unit

---
 rtl/bitty_fetch_unit_if.sv | 33 +++
 rtl/bitty_fetch_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/bitty_fetch_unit_if.sv
// Instruction-memory bus and bitty_core handshake for bitty_fetch_unit.
//   mem_addr/mem_rd    : fetch request (data returns the following cycle)
//   mem_data           : instruction word from memory
//   core_instruction   : registered instruction presented to the core
//   core_run/core_done : one-cycle run pulse out, completion pulse back
interface bitty_fetch_unit_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [15:0]       mem_data;
  logic [15:0]       core_instruction;
  logic              core_run;
  logic              core_done;

  modport master (
    output mem_addr,
    output mem_rd,
    output core_instruction,
    output core_run,
    input  mem_data,
    input  core_done
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    input  core_instruction,
    input  core_run,
    output mem_data,
    output core_done
  );
endinterface

// File: rtl/bitty_fetch_unit.sv
// Fetch/issue sequencer for bitty_core: reads one instruction per step,
// issues it with a run pulse, waits for completion under a watchdog.
//   clk, rst (sync, active-high)
//   start/start_addr : launch from IDLE or ERR
//   halt_req         : stop after the instruction in flight
//   bus (master)     : memory fetch and core handshake
//   busy, pc, instr_count, timeout_err : status
module bitty_fetch_unit #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic                  halt_req,
  bitty_fetch_unit_if.master    bus,
  output logic                  busy,
  output logic [ADDR_W-1:0]     pc,
  output logic [15:0]           instr_count,
  output logic                  timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_MEM,
    ISSUE,
    EXEC,
    ERR
  } state_e;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic [15:0]       count_q, count_d;
  logic              err_q, err_d;
  logic              halt_q, halt_d;
  logic [7:0]        wd_q, wd_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    err_d   = err_q;
    halt_d  = halt_q;
    wd_d    = wd_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = start_addr;
          count_d = '0;
          halt_d  = 1'b0;
        end
      end

      FETCH: begin
        state_d = WAIT_MEM;
        if (halt_req) halt_d = 1'b1;
      end

      WAIT_MEM: begin
        instr_d = bus.mem_data;
        state_d = ISSUE;
        if (halt_req) halt_d = 1'b1;
      end

      ISSUE: begin
        wd_d    = '0;
        state_d = EXEC;
        if (halt_req) halt_d = 1'b1;
      end

      EXEC: begin
        if (halt_req) halt_d = 1'b1;
        // Completion is checked first so a done on the last watchdog cycle retires normally.
        if (bus.core_done) begin
          pc_d    = pc_q + ADDR_W'(1);
          count_d = (count_q == '1) ? count_q : count_q + 16'd1;
          if (halt_q || halt_req) begin
            state_d = IDLE;
            halt_d  = 1'b0;
          end else begin
            state_d = FETCH;
          end
        end else if (wd_q == WD_LAST) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end

      ERR: begin
        if (start) begin
          state_d = FETCH;
          err_d   = 1'b0;
          pc_d    = start_addr;
          count_d = '0;
          halt_d  = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      halt_q  <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
      err_q   <= err_d;
      halt_q  <= halt_d;
      wd_q    <= wd_d;
    end
  end

  assign bus.mem_rd           = (state_q == FETCH);
  assign bus.core_run         = (state_q == ISSUE);
  assign bus.mem_addr         = pc_q;
  assign bus.core_instruction = instr_q;
  assign busy                 = (state_q != IDLE) && (state_q != ERR);
  assign pc                   = pc_q;
  assign instr_count          = count_q;
  assign timeout_err          = err_q;

endmodule
